// File: rtl/mask_arb_pkg.sv
// Shared types and helper functions for the mask-based round-robin arbiter family.
package mask_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Ceiling log2 with a floor of 1 so a 2-way arbiter still gets a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int lsb_index(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] lsb_onehot(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/prio_arbiter_n.sv
// Fixed-priority arbiter, bit 0 highest: one-hot grant, its index and an any-request flag.
module prio_arbiter_n
    import mask_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = clog2(N)
) (
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    always_comb begin
        grant = req & (~req + N'(1));
        idx   = IDXW'(lsb_index(32'(req)));
        any   = |req;
    end

endmodule

// File: rtl/mask_rr_arbiter_n.sv
// N-way mask-based round-robin arbiter with registered one-hot grant, grant
// locking, optional hold limit and a timeout pulse.
module mask_rr_arbiter_n
    import mask_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 0,
    parameter int IDXW     = clog2(N),
    parameter int HCW      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            release_grant,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            hold_timeout
);

    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam bit             HOLD_LIMITED = (MAX_HOLD != 0);

    arb_state_t      state, state_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [HCW-1:0]  hold_cnt, hold_nxt;
    logic [N-1:0]    grant_nxt;
    logic [IDXW-1:0] idx_nxt;
    logic            valid_nxt;
    logic            timeout_nxt;

    logic [N-1:0]    mask;
    logic [N-1:0]    cand;
    logic            owner_req;
    logic            timeout;
    logic            release_cond;
    logic            do_arb;

    logic [N-1:0]    m_grant, u_grant;
    logic [IDXW-1:0] m_idx, u_idx;
    logic            m_any, u_any;

    // Candidate set: everyone in IDLE; on a release the owner is excluded
    // unless it is the sole requester and was cut off by timeout or pulse.
    always_comb begin
        mask      = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        owner_req    = |(req & grant);
        timeout      = HOLD_LIMITED && (hold_cnt == HOLD_LAST);
        release_cond = !owner_req || release_grant || timeout;
        cand         = '0;
        do_arb       = 1'b0;
        if (state == IDLE) begin
            cand   = req;
            do_arb = 1'b1;
        end else if (release_cond) begin
            cand   = (req == grant) ? req : (req & ~grant);
            do_arb = 1'b1;
        end
    end

    prio_arbiter_n #(.N(N), .IDXW(IDXW)) u_masked (
        .req   (cand & mask),
        .grant (m_grant),
        .idx   (m_idx),
        .any   (m_any)
    );

    prio_arbiter_n #(.N(N), .IDXW(IDXW)) u_unmasked (
        .req   (cand),
        .grant (u_grant),
        .idx   (u_idx),
        .any   (u_any)
    );

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        grant_nxt   = grant;
        idx_nxt     = grant_idx;
        valid_nxt   = grant_valid;
        timeout_nxt = (state == OWN) && timeout;
        if (do_arb) begin
            if (u_any) begin
                state_nxt = OWN;
                valid_nxt = 1'b1;
                hold_nxt  = '0;
                grant_nxt = m_any ? m_grant : u_grant;
                idx_nxt   = m_any ? m_idx : u_idx;
                ptr_nxt   = (idx_nxt == IDXW'(N - 1)) ? '0 : idx_nxt + IDXW'(1);
            end else begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                hold_nxt  = '0;
                grant_nxt = '0;
                idx_nxt   = '0;
            end
        end else if (state == OWN) begin
            hold_nxt = (hold_cnt == '1) ? hold_cnt : hold_cnt + HCW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            hold_cnt     <= '0;
            grant        <= '0;
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
            hold_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            hold_cnt     <= hold_nxt;
            grant        <= grant_nxt;
            grant_idx    <= idx_nxt;
            grant_valid  <= valid_nxt;
            hold_timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_mask_rr_arbiter_n.sv
// Self-checking bench for mask_rr_arbiter_n: directed scenarios on several
// configurations plus a randomized run against a rotating-search reference model.
module tb_mask_rr_arbiter_n;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: N=4, unlimited hold
    logic [3:0] req_a;
    logic       rel_a;
    logic [3:0] grant_a;
    logic [1:0] idx_a;
    logic       valid_a, tmo_a;
    // B: N=4, MAX_HOLD=3
    logic [3:0] req_b;
    logic       rel_b;
    logic [3:0] grant_b;
    logic [1:0] idx_b;
    logic       valid_b, tmo_b;
    // C: N=8, unlimited hold
    logic [7:0] req_c;
    logic       rel_c;
    logic [7:0] grant_c;
    logic [2:0] idx_c;
    logic       valid_c, tmo_c;
    // D: N=5, MAX_HOLD=7
    logic [4:0] req_d;
    logic       rel_d;
    logic [4:0] grant_d;
    logic [2:0] idx_d;
    logic       valid_d, tmo_d;

    mask_rr_arbiter_n #(.N(4), .MAX_HOLD(0)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .release_grant(rel_a),
        .grant(grant_a), .grant_idx(idx_a), .grant_valid(valid_a), .hold_timeout(tmo_a)
    );
    mask_rr_arbiter_n #(.N(4), .MAX_HOLD(3)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .release_grant(rel_b),
        .grant(grant_b), .grant_idx(idx_b), .grant_valid(valid_b), .hold_timeout(tmo_b)
    );
    mask_rr_arbiter_n #(.N(8), .MAX_HOLD(0)) dut_c (
        .clk(clk), .reset(reset), .req(req_c), .release_grant(rel_c),
        .grant(grant_c), .grant_idx(idx_c), .grant_valid(valid_c), .hold_timeout(tmo_c)
    );
    mask_rr_arbiter_n #(.N(5), .MAX_HOLD(7)) dut_d (
        .clk(clk), .reset(reset), .req(req_d), .release_grant(rel_d),
        .grant(grant_d), .grant_idx(idx_d), .grant_valid(valid_d), .hold_timeout(tmo_d)
    );

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_a = '0; rel_a = 1'b0;
        req_b = '0; rel_b = 1'b0;
        req_c = '0; rel_c = 1'b0;
        req_d = '0; rel_d = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (grant_a !== 4'b0 || idx_a !== 2'd0 || valid_a !== 1'b0 || tmo_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_a got grant=%b idx=%0d valid=%b tmo=%b, expected all zero", grant_a, idx_a, valid_a, tmo_a);
        end
        checks++;
        if (grant_b !== 4'b0 || idx_b !== 2'd0 || valid_b !== 1'b0 || tmo_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_b got grant=%b idx=%0d valid=%b tmo=%b, expected all zero", grant_b, idx_b, valid_b, tmo_b);
        end
        checks++;
        if (grant_c !== 8'b0 || idx_c !== 3'd0 || valid_c !== 1'b0 || tmo_c !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_c got grant=%b idx=%0d valid=%b tmo=%b, expected all zero", grant_c, idx_c, valid_c, tmo_c);
        end
        checks++;
        if (grant_d !== 5'b0 || idx_d !== 3'd0 || valid_d !== 1'b0 || tmo_d !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_d got grant=%b idx=%0d valid=%b tmo=%b, expected all zero", grant_d, idx_d, valid_d, tmo_d);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // All four request; each owner drops its request after one cycle.
    task automatic test_round_robin();
        logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int         exp_idx [5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_a = 4'b1111;
        checks++;
        if (grant_a !== 4'b0) begin
            errors++;
            $display("[TB] FAIL rr_latency got grant=%b before clock edge, expected 0000", grant_a);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (grant_a !== exp_seq[k] || int'(idx_a) != exp_idx[k] || valid_a !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rr_seq[%0d] got grant=%b idx=%0d valid=%b, expected grant=%b idx=%0d valid=1",
                         k, grant_a, idx_a, valid_a, exp_seq[k], exp_idx[k]);
            end
            req_a = 4'b1111 & ~exp_seq[k];
        end
        req_a = '0;
        @(negedge clk);
    endtask

    // Sole requester with MAX_HOLD=3: timeout pulse and re-grant with no gap.
    task automatic test_hold_timeout();
        do_reset();
        req_b = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (grant_b !== 4'b0100 || tmo_b !== 1'b0 || idx_b !== 2'd2) begin
                errors++;
                $display("[TB] FAIL hold_cycle[%0d] got grant=%b idx=%0d tmo=%b, expected grant=0100 idx=2 tmo=0", k, grant_b, idx_b, tmo_b);
            end
        end
        @(negedge clk);
        checks++;
        if (grant_b !== 4'b0100 || tmo_b !== 1'b1 || valid_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_pulse got grant=%b valid=%b tmo=%b, expected grant=0100 valid=1 tmo=1", grant_b, valid_b, tmo_b);
        end
        @(negedge clk);
        checks++;
        if (grant_b !== 4'b0100 || tmo_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_single got grant=%b tmo=%b, expected grant=0100 tmo=0", grant_b, tmo_b);
        end
        req_b = '0;
        @(negedge clk);
    endtask

    // Owner 1 holds, others request; release pulse hands over to the masked side.
    task automatic test_release_mask();
        do_reset();
        req_a = 4'b0010;
        @(negedge clk);
        req_a = 4'b1011;
        @(negedge clk);
        checks++;
        if (grant_a !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL lock_hold got grant=%b, expected 0010", grant_a);
        end
        rel_a = 1'b1;
        @(negedge clk);
        rel_a = 1'b0;
        checks++;
        if (grant_a !== 4'b1000 || idx_a !== 2'd3) begin
            errors++;
            $display("[TB] FAIL release_masked got grant=%b idx=%0d, expected grant=1000 idx=3", grant_a, idx_a);
        end
        req_a = 4'b0011;
        @(negedge clk);
        checks++;
        if (grant_a !== 4'b0001 || idx_a !== 2'd0) begin
            errors++;
            $display("[TB] FAIL after_drop got grant=%b idx=%0d, expected grant=0001 idx=0", grant_a, idx_a);
        end
        req_a = '0;
        @(negedge clk);
    endtask

    // N=8: owner 7 drops, pointer wraps so lowest index wins.
    task automatic test_wrap();
        do_reset();
        req_c = 8'b1000_0000;
        @(negedge clk);
        checks++;
        if (grant_c !== 8'b1000_0000 || idx_c !== 3'd7) begin
            errors++;
            $display("[TB] FAIL wrap_owner7 got grant=%b idx=%0d, expected grant=10000000 idx=7", grant_c, idx_c);
        end
        req_c = 8'b0000_0110;
        @(negedge clk);
        checks++;
        if (grant_c !== 8'b0000_0010 || idx_c !== 3'd1 || valid_c !== 1'b1 || tmo_c !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_grant got grant=%b idx=%0d valid=%b tmo=%b, expected grant=00000010 idx=1 valid=1 tmo=0",
                     grant_c, idx_c, valid_c, tmo_c);
        end
        req_c = '0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        req_a = 4'b0010;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (grant_a !== 4'b0 || valid_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_clear got grant=%b valid=%b, expected grant=0000 valid=0", grant_a, valid_a);
        end
        @(negedge clk);
        reset = 1'b0;
        req_a = 4'b1000;
        checks++;
        if (grant_a !== 4'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_latency got grant=%b, expected 0000", grant_a);
        end
        @(negedge clk);
        checks++;
        if (grant_a !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL post_reset_grant got grant=%b, expected 1000", grant_a);
        end
        do_reset();
        req_a = 4'b0011;
        @(negedge clk);
        checks++;
        if (grant_a !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL post_reset_ptr got grant=%b, expected 0001", grant_a);
        end
        req_a = '0;
        @(negedge clk);
    endtask

    // Reference: the next owner is the first candidate found walking upward
    // from the pointer, wrapping around; owner keeps the grant up to 7 cycles.
    task automatic test_random();
        int         own;
        int         ptr;
        int         hold;
        int         w;
        int         j;
        int         wait_cnt [5];
        bit         exp_tmo;
        bit         tmo;
        bit         relc;
        bit         arb;
        logic [4:0] r;
        logic [4:0] cand;
        logic [4:0] exp_grant;
        bit         rl;
        do_reset();
        own  = -1;
        ptr  = 0;
        hold = 0;
        r    = '0;
        for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(3) == 0) r[i] = ~r[i];
            end
            rl    = ($urandom_range(7) == 0);
            req_d = r;
            rel_d = rl;

            exp_tmo = 1'b0;
            arb     = 1'b0;
            cand    = '0;
            if (own < 0) begin
                cand = r;
                arb  = 1'b1;
            end else begin
                tmo     = (hold == 6);
                relc    = !r[own] || rl || tmo;
                exp_tmo = tmo;
                if (!relc) begin
                    hold++;
                end else begin
                    arb  = 1'b1;
                    cand = r;
                    if (r != (5'd1 << own)) cand[own] = 1'b0;
                end
            end
            if (arb) begin
                w = -1;
                for (int k = 0; k < 5; k++) begin
                    j = (ptr + k) % 5;
                    if (w < 0 && cand[j]) w = j;
                end
                own  = w;
                hold = 0;
                if (w >= 0) ptr = (w + 1) % 5;
            end

            @(negedge clk);
            exp_grant = (own < 0) ? 5'b0 : (5'd1 << own);
            checks++;
            if (grant_d !== exp_grant || valid_d !== (own >= 0)) begin
                errors++;
                $display("[TB] FAIL rand_grant cyc=%0d got grant=%b valid=%b, expected grant=%b valid=%b",
                         cyc, grant_d, valid_d, exp_grant, own >= 0);
            end
            checks++;
            if (int'(idx_d) != ((own < 0) ? 0 : own)) begin
                errors++;
                $display("[TB] FAIL rand_idx cyc=%0d got idx=%0d, expected %0d", cyc, idx_d, (own < 0) ? 0 : own);
            end
            checks++;
            if (tmo_d !== exp_tmo) begin
                errors++;
                $display("[TB] FAIL rand_timeout cyc=%0d got tmo=%b, expected %b", cyc, tmo_d, exp_tmo);
            end
            checks++;
            if ($countones(grant_d) > 1) begin
                errors++;
                $display("[TB] FAIL rand_onehot cyc=%0d got grant=%b, expected at most one bit set", cyc, grant_d);
            end
            for (int i = 0; i < 5; i++) begin
                if (r[i] && grant_d[i] !== 1'b1) wait_cnt[i]++;
                else wait_cnt[i] = 0;
            end
            checks++;
            for (int i = 0; i < 5; i++) begin
                if (wait_cnt[i] > 32) begin
                    errors++;
                    $display("[TB] FAIL rand_starve cyc=%0d requester %0d waited %0d cycles, expected at most 32", cyc, i, wait_cnt[i]);
                    wait_cnt[i] = 0;
                end
            end
        end
        req_d = '0;
        rel_d = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hold_timeout();
        test_release_mask();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
